// File: rtl/intc_pkg.sv
// intc_pkg: shared definitions for the intc_multi interrupt controller.
// Holds the register map, the STATUS word layout and the priority encoder
// used both for request arbitration and for in-service lookup.
package intc_pkg;

    typedef enum logic [1:0] {
        REG_PENDING = 2'd0,
        REG_ENABLE  = 2'd1,
        REG_MODE    = 2'd2,
        REG_STATUS  = 2'd3
    } reg_addr_e;

    localparam int REG_DATA_W      = 16;
    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_ID_LSB   = 1;
    localparam int STATUS_ID_W     = 4;

    // Lowest set index wins; returns 0 when nothing is set.
    function automatic logic [3:0] prio_enc16(input logic [15:0] req);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (req[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [REG_DATA_W-1:0] pack_status(input logic [3:0] id,
                                                          input logic busy);
        logic [REG_DATA_W-1:0] w;
        w = '0;
        w[STATUS_ID_LSB +: STATUS_ID_W] = id;
        w[STATUS_BUSY_BIT] = busy;
        return w;
    endfunction

endpackage

// File: rtl/intc_sync.sv
// intc_sync: one interrupt channel front end. Two-flop synchronizer for an
// asynchronous source plus a rising-edge detector on the synchronized level.
module intc_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic src_in,
    output logic sync_out,
    output logic rise
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    // Shift the raw source through the synchronizer and keep one delayed copy for edge detection.
    always_comb begin
        meta_d = src_in;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // Synchronizer and edge-history registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync_out = sync_q;
    assign rise     = sync_q & ~prev_q;

endmodule

// File: rtl/intc_multi.sv
// intc_multi: vectored interrupt controller with fixed priority (lowest index
// wins), per-source edge/level mode and a small PENDING/ENABLE/MODE/STATUS
// register file. Build option INTC_NEST_EN: in-service state becomes a vector
// and a higher-priority source may preempt a running handler; without it a
// single busy flag blocks all new requests until iret.
module intc_multi
    import intc_pkg::*;
#(
    parameter int  NUM_IRQ    = 8,
    parameter int  ADDR_WIDTH = 12,
    parameter int  VEC_BASE   = 'h900,
    parameter int  VEC_STRIDE = 'h10,
    localparam int ID_W       = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_IRQ-1:0]    irq_src,
    output logic                  irq,
    input  logic                  irq_ack,
    input  logic                  iret,
    output logic [ID_W-1:0]       vec_id,
    output logic [ADDR_WIDTH-1:0] vec_addr,
    input  logic [1:0]            reg_addr,
    input  logic                  reg_wen,
    input  logic                  reg_ren,
    input  logic [15:0]           reg_wdata,
    output logic [15:0]           reg_rdata
);

    logic [NUM_IRQ-1:0] sync_lvl, sync_rise;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] enable_q, enable_d;
    logic [NUM_IRQ-1:0] mode_q, mode_d;
    logic               irq_q, irq_d;
    logic [ID_W-1:0]    vec_id_q, vec_id_d;
    logic [15:0]        reg_rdata_q, reg_rdata_d;

    logic               ack_take;
    logic [NUM_IRQ-1:0] ack_onehot, w1c_mask, req, wdata_bits;
    logic               win_valid, admit, busy;
    logic [ID_W-1:0]    win_id;
    logic [3:0]         isv_id;
    reg_addr_e          addr_sel;
    logic               unused_wdata;

    assign addr_sel     = reg_addr_e'(reg_addr);
    assign wdata_bits   = reg_wdata[NUM_IRQ-1:0];
    assign unused_wdata = ^reg_wdata;

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
        intc_sync u_sync (
            .clk      (clk),
            .rst_n    (rst_n),
            .src_in   (irq_src[g]),
            .sync_out (sync_lvl[g]),
            .rise     (sync_rise[g])
        );
    end

    // Arbitration: an ack only counts while irq is presented; lowest enabled pending index wins.
    always_comb begin
        ack_take   = irq_ack & irq_q;
        ack_onehot = NUM_IRQ'(ack_take) << vec_id_q;
        req        = pending_q & enable_q;
        win_valid  = |req;
        win_id     = ID_W'(prio_enc16(16'(req)));
    end

    // Register writes and PENDING update; a fresh edge beats a same-cycle clear, level bits just follow the input.
    always_comb begin
        enable_d = enable_q;
        mode_d   = mode_q;
        w1c_mask = '0;
        if (reg_wen) begin
            unique case (addr_sel)
                REG_PENDING: w1c_mask = wdata_bits;
                REG_ENABLE:  enable_d = wdata_bits;
                REG_MODE:    mode_d   = wdata_bits;
                REG_STATUS:  ;
            endcase
        end
        pending_d = (mode_q & ((pending_q & ~(w1c_mask | ack_onehot)) | sync_rise))
                  | (~mode_q & sync_lvl);
    end

`ifdef INTC_NEST_EN
    logic [NUM_IRQ-1:0] isv_q, isv_d, isv_after_iret;

    // Nested in-service: iret retires the lowest-index handler first, then a same-cycle ack adds the new one.
    always_comb begin
        isv_after_iret = iret ? (isv_q & (isv_q - NUM_IRQ'(1))) : isv_q;
        isv_d          = isv_after_iret | ack_onehot;
        admit          = (isv_d == '0) || (4'(win_id) < prio_enc16(16'(isv_d)));
        busy           = |isv_q;
        isv_id         = prio_enc16(16'(isv_q));
    end

    // In-service vector register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            isv_q <= '0;
        end else begin
            isv_q <= isv_d;
        end
    end
`else
    logic            busy_q, busy_d;
    logic [ID_W-1:0] isv_id_q, isv_id_d;

    // Single handler at a time: iret frees the slot before a same-cycle ack claims it.
    always_comb begin
        busy_d   = busy_q;
        isv_id_d = isv_id_q;
        if (iret) begin
            busy_d   = 1'b0;
            isv_id_d = '0;
        end
        if (ack_take) begin
            busy_d   = 1'b1;
            isv_id_d = vec_id_q;
        end
        admit  = ~busy_d;
        busy   = busy_q;
        isv_id = 4'(isv_id_q);
    end

    // Busy flag and ID of the running handler.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            isv_id_q <= '0;
        end else begin
            busy_q   <= busy_d;
            isv_id_q <= isv_id_d;
        end
    end
`endif

    // Request outputs use next in-service state so irq drops right after an ack; read data only moves on reg_ren.
    always_comb begin
        irq_d       = win_valid & admit;
        vec_id_d    = win_valid ? win_id : vec_id_q;
        reg_rdata_d = reg_rdata_q;
        if (reg_ren) begin
            unique case (addr_sel)
                REG_PENDING: reg_rdata_d = 16'(pending_q);
                REG_ENABLE:  reg_rdata_d = 16'(enable_q);
                REG_MODE:    reg_rdata_d = 16'(mode_q);
                REG_STATUS:  reg_rdata_d = pack_status(isv_id, busy);
            endcase
        end
    end

    // Controller state registers; MODE resets to edge for every source.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q   <= '0;
            enable_q    <= '0;
            mode_q      <= '1;
            irq_q       <= 1'b0;
            vec_id_q    <= '0;
            reg_rdata_q <= '0;
        end else begin
            pending_q   <= pending_d;
            enable_q    <= enable_d;
            mode_q      <= mode_d;
            irq_q       <= irq_d;
            vec_id_q    <= vec_id_d;
            reg_rdata_q <= reg_rdata_d;
        end
    end

    assign irq       = irq_q;
    assign vec_id    = vec_id_q;
    assign vec_addr  = ADDR_WIDTH'(VEC_BASE + VEC_STRIDE * int'(vec_id_q));
    assign reg_rdata = reg_rdata_q;

endmodule

// File: tb/tb_intc_multi.sv
// tb_intc_multi: directed bench for intc_multi (NUM_IRQ=8, base 'h900,
// stride 'h10). Expected values are queued as each step is driven and popped
// when the corresponding output is sampled, one tick after the clock edge.
module tb_intc_multi;

    logic        clk;
    logic        rst_n;
    logic [7:0]  irq_src;
    logic        irq;
    logic        irq_ack;
    logic        iret;
    logic [2:0]  vec_id;
    logic [11:0] vec_addr;
    logic [1:0]  reg_addr;
    logic        reg_wen;
    logic        reg_ren;
    logic [15:0] reg_wdata;
    logic [15:0] reg_rdata;

    int          vectors     = 0;
    int          miscompares = 0;
    string       tag_q[$];
    logic [31:0] exp_q[$];

    intc_multi #(
        .NUM_IRQ    (8),
        .ADDR_WIDTH (12),
        .VEC_BASE   ('h900),
        .VEC_STRIDE ('h10)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .irq_src   (irq_src),
        .irq       (irq),
        .irq_ack   (irq_ack),
        .iret      (iret),
        .vec_id    (vec_id),
        .vec_addr  (vec_addr),
        .reg_addr  (reg_addr),
        .reg_wen   (reg_wen),
        .reg_ren   (reg_ren),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout, expected sequence completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance n clock edges and settle just after the last one.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive sources plus one-cycle ack/iret pulses across one clock edge.
    task automatic applyStimulus(input logic [7:0] src, input logic ack, input logic ret);
        irq_src = src;
        irq_ack = ack;
        iret    = ret;
        step(1);
        irq_ack = 1'b0;
        iret    = 1'b0;
    endtask

    // Queue an expected value for the next sampled output.
    task automatic expectVal(input string tag, input logic [31:0] val);
        tag_q.push_back(tag);
        exp_q.push_back(val);
    endtask

    // Pop the oldest expectation and compare it against the sampled output.
    task automatic checkOutput(input logic [31:0] obs);
        string       tag;
        logic [31:0] exp;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $error("[TB] FAIL scoreboard_empty: observed 0x%0h, expected a queued value", obs);
            return;
        end
        tag = tag_q.pop_front();
        exp = exp_q.pop_front();
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Single-cycle register write.
    task automatic regWrite(input logic [1:0] addr, input logic [15:0] data);
        reg_addr  = addr;
        reg_wdata = data;
        reg_wen   = 1'b1;
        step(1);
        reg_wen   = 1'b0;
        reg_wdata = 16'h0000;
    endtask

    // Register read: data is valid one edge after the strobe.
    task automatic regCheck(input logic [1:0] addr, input string tag, input logic [15:0] exp);
        expectVal(tag, 32'(exp));
        reg_addr = addr;
        reg_ren  = 1'b1;
        step(1);
        reg_ren  = 1'b0;
        checkOutput(32'(reg_rdata));
    endtask

    // Main directed sequence.
    initial begin
        rst_n     = 1'b1;
        irq_src   = '0;
        irq_ack   = 1'b0;
        iret      = 1'b0;
        reg_addr  = 2'd0;
        reg_wen   = 1'b0;
        reg_ren   = 1'b0;
        reg_wdata = '0;
        #2 rst_n  = 1'b0;
        step(1);

        // Reset values while held in reset.
        expectVal("rst_irq", 0);
        expectVal("rst_vec_id", 0);
        expectVal("rst_vec_addr", 'h900);
        expectVal("rst_rdata", 0);
        checkOutput(32'(irq));
        checkOutput(32'(vec_id));
        checkOutput(32'(vec_addr));
        checkOutput(32'(reg_rdata));
        rst_n = 1'b1;
        step(1);
        regCheck(2'd0, "rst_pending", 16'h0000);
        regCheck(2'd1, "rst_enable", 16'h0000);
        regCheck(2'd2, "rst_mode", 16'h00FF);
        expectVal("rdata_hold", 'h00FF);
        step(2);
        checkOutput(32'(reg_rdata));
        regCheck(2'd3, "rst_status", 16'h0000);

        // Basic: single edge source, three-edge latency, ack clears.
        regWrite(2'd1, 16'h0008);
        applyStimulus(8'h08, 1'b0, 1'b0);
        expectVal("basic_irq_k2", 0);
        step(2);
        checkOutput(32'(irq));
        expectVal("basic_irq_k3", 1);
        expectVal("basic_vec_id", 3);
        expectVal("basic_vec_addr", 'h930);
        step(1);
        checkOutput(32'(irq));
        checkOutput(32'(vec_id));
        checkOutput(32'(vec_addr));
        expectVal("basic_irq_after_ack", 0);
        applyStimulus(8'h00, 1'b1, 1'b0);
        checkOutput(32'(irq));
        regCheck(2'd0, "basic_pending", 16'h0000);
        regCheck(2'd3, "basic_status_busy", 16'h0007);
        applyStimulus(8'h00, 1'b0, 1'b1);
        regCheck(2'd3, "basic_status_iret", 16'h0000);

        // Priority: sources 5 and 2 together.
        regWrite(2'd1, 16'h00FF);
        applyStimulus(8'h24, 1'b0, 1'b0);
        expectVal("prio_irq", 1);
        expectVal("prio_vec_id", 2);
        expectVal("prio_vec_addr", 'h920);
        step(3);
        checkOutput(32'(irq));
        checkOutput(32'(vec_id));
        checkOutput(32'(vec_addr));
        expectVal("prio_irq_ack", 0);
        applyStimulus(8'h00, 1'b1, 1'b0);
        checkOutput(32'(irq));
        expectVal("prio_irq_next", 1);
        expectVal("prio_vec_id_next", 5);
        expectVal("prio_vec_addr_next", 'h950);
        applyStimulus(8'h00, 1'b0, 1'b1);
        checkOutput(32'(irq));
        checkOutput(32'(vec_id));
        checkOutput(32'(vec_addr));
        applyStimulus(8'h00, 1'b1, 1'b0);
        expectVal("prio_idle", 0);
        applyStimulus(8'h00, 1'b0, 1'b1);
        checkOutput(32'(irq));

        // Nesting: source 4 in service, then source 1, then source 6.
        applyStimulus(8'h10, 1'b0, 1'b0);
        expectVal("nest_vec_id4", 4);
        step(3);
        checkOutput(32'(vec_id));
        applyStimulus(8'h00, 1'b1, 1'b0);
        applyStimulus(8'h02, 1'b0, 1'b0);
`ifdef INTC_NEST_EN
        expectVal("nest_preempt_irq", 1);
        expectVal("nest_preempt_addr", 'h910);
        step(3);
        checkOutput(32'(irq));
        checkOutput(32'(vec_addr));
        expectVal("nest_ack1_irq", 0);
        applyStimulus(8'h00, 1'b1, 1'b0);
        checkOutput(32'(irq));
        expectVal("nest_src6_blocked", 0);
        applyStimulus(8'h40, 1'b0, 1'b0);
        step(3);
        checkOutput(32'(irq));
        expectVal("nest_iret1_irq", 0);
        applyStimulus(8'h00, 1'b0, 1'b1);
        checkOutput(32'(irq));
`else
        expectVal("flat_src1_held", 0);
        step(3);
        checkOutput(32'(irq));
        expectVal("flat_src6_held", 0);
        applyStimulus(8'h40, 1'b0, 1'b0);
        step(3);
        checkOutput(32'(irq));
        expectVal("flat_iret_irq", 1);
        expectVal("flat_iret_addr", 'h910);
        applyStimulus(8'h00, 1'b0, 1'b1);
        checkOutput(32'(irq));
        checkOutput(32'(vec_addr));
        applyStimulus(8'h00, 1'b1, 1'b0);
`endif
        expectVal("nest_final_irq", 1);
        expectVal("nest_final_vec_id", 6);
        applyStimulus(8'h00, 1'b0, 1'b1);
        checkOutput(32'(irq));
        checkOutput(32'(vec_id));
        applyStimulus(8'h00, 1'b1, 1'b0);
        applyStimulus(8'h00, 1'b0, 1'b1);
        regCheck(2'd3, "nest_status_idle", 16'h0000);

        // Level mode: source 0 held high through ack and iret, then dropped.
        regWrite(2'd2, 16'h0000);
        applyStimulus(8'h01, 1'b0, 1'b0);
        expectVal("lvl_irq", 1);
        expectVal("lvl_vec_id", 0);
        expectVal("lvl_vec_addr", 'h900);
        step(3);
        checkOutput(32'(irq));
        checkOutput(32'(vec_id));
        checkOutput(32'(vec_addr));
        expectVal("lvl_ack_irq", 0);
        applyStimulus(8'h01, 1'b1, 1'b0);
        checkOutput(32'(irq));
        regCheck(2'd0, "lvl_pending_held", 16'h0001);
        expectVal("lvl_reassert", 1);
        applyStimulus(8'h01, 1'b0, 1'b1);
        checkOutput(32'(irq));
        applyStimulus(8'h00, 1'b0, 1'b0);
        regCheck(2'd0, "lvl_pend_e0", 16'h0001);
        regCheck(2'd0, "lvl_pend_e1", 16'h0001);
        regCheck(2'd0, "lvl_pend_e2", 16'h0000);
        expectVal("lvl_irq_gone", 0);
        checkOutput(32'(irq));
        regWrite(2'd2, 16'h00FF);

        // Races: edge beats W1C, plain W1C clears; idle iret and stray ack ignored.
        regWrite(2'd1, 16'h0000);
        applyStimulus(8'h08, 1'b0, 1'b0);
        step(3);
        regCheck(2'd0, "race_pre", 16'h0008);
        applyStimulus(8'h00, 1'b0, 1'b0);
        step(3);
        applyStimulus(8'h08, 1'b0, 1'b0);
        step(1);
        regWrite(2'd0, 16'h0008);
        regCheck(2'd0, "race_edge_wins", 16'h0008);
        regWrite(2'd0, 16'h0008);
        regCheck(2'd0, "w1c_clears", 16'h0000);
        applyStimulus(8'h00, 1'b0, 1'b1);
        regCheck(2'd3, "idle_iret_status", 16'h0000);
        expectVal("idle_ack_irq", 0);
        applyStimulus(8'h00, 1'b1, 1'b0);
        checkOutput(32'(irq));
        regCheck(2'd3, "idle_ack_status", 16'h0000);

        // Reset in the middle of servicing source 1 with sources 0 and 5 pending.
        regWrite(2'd1, 16'h0002);
        applyStimulus(8'h23, 1'b0, 1'b0);
        expectVal("mid_irq", 1);
        expectVal("mid_vec_id", 1);
        step(3);
        checkOutput(32'(irq));
        checkOutput(32'(vec_id));
        applyStimulus(8'h00, 1'b1, 1'b0);
        regCheck(2'd3, "mid_status", 16'h0003);
        regCheck(2'd0, "mid_pending", 16'h0021);
        rst_n = 1'b0;
        #1;
        expectVal("mid_rst_irq", 0);
        expectVal("mid_rst_vec_id", 0);
        expectVal("mid_rst_vec_addr", 'h900);
        expectVal("mid_rst_rdata", 0);
        checkOutput(32'(irq));
        checkOutput(32'(vec_id));
        checkOutput(32'(vec_addr));
        checkOutput(32'(reg_rdata));
        step(2);
        rst_n = 1'b1;
        expectVal("post_rst_irq", 0);
        step(4);
        checkOutput(32'(irq));
        regCheck(2'd0, "post_rst_pending", 16'h0000);
        regCheck(2'd1, "post_rst_enable", 16'h0000);
        regCheck(2'd2, "post_rst_mode", 16'h00FF);
        regCheck(2'd3, "post_rst_status", 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/intc_multi.md
INTC_MULTI -- requirements
Module: intc_multi

Interface
REQ-001 Parameter NUM_IRQ, 8, number of interrupt sources, legal range 1..16.
REQ-002 Parameter ADDR_WIDTH, 12, width of the vector address, matching the CPU program-memory address width.
REQ-003 Parameter VEC_BASE, 'h900, vector address of source 0.
REQ-004 Parameter VEC_STRIDE, 'h10, vector address spacing between consecutive sources.
REQ-005 clk  in  1  single clock; all state updates on posedge clk.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 irq_src  in  NUM_IRQ  raw interrupt sources, asynchronous to clk.
REQ-008 irq  out  1  interrupt request to CPU; registered output.
REQ-009 irq_ack  in  1  one-cycle pulse from CPU: the currently presented vector was taken.
REQ-010 iret  in  1  one-cycle pulse from CPU: the current service routine has finished.
REQ-011 vec_id  out  $clog2(NUM_IRQ) (min 1)  ID of the highest-priority request; registered.
REQ-012 vec_addr  out  ADDR_WIDTH  VEC_BASE + vec_id*VEC_STRIDE, truncated to ADDR_WIDTH.
REQ-013 reg_addr  in  2  register select: 0 PENDING, 1 ENABLE, 2 MODE, 3 STATUS.
REQ-014 reg_wen, reg_ren  in  1 each  register write and read strobes.
REQ-015 reg_wdata  in  16  write data; reg_rdata  out  16  read data; bits above NUM_IRQ are ignored on write and read as 0.

Function
REQ-016 Each source SHALL pass through a 2-flop synchronizer; edge mode (MODE bit = 1) SHALL set PENDING on a 0->1 transition of the synchronized signal.
REQ-017 In level mode (MODE bit = 0), PENDING SHALL mirror the synchronized level; W1C and ack SHALL have no effect on that bit.
REQ-018 Source latency: irq_src high sampled at clock edge k -> PENDING set after edge k+2 -> irq and vec_id valid after edge k+3.
REQ-019 Priority is fixed: the lowest index SHALL win among PENDING & ENABLE bits.
REQ-020 irq SHALL be 1 only when a winner exists and it is admitted by the in-service rule (REQ-031/032).
REQ-021 irq_ack with irq=1: set the in-service bit of vec_id; clear PENDING[vec_id] if that source is in edge mode; irq SHALL read 0 after the next edge.
REQ-022 irq_ack with irq=0 SHALL be ignored.
REQ-023 iret SHALL clear the highest-priority (lowest-index) set in-service bit; iret with nothing in service SHALL be ignored.
REQ-024 When iret and irq_ack occur in the same cycle, iret SHALL be applied to the in-service state first, then ack.
REQ-025 When a new edge and a PENDING clear (ack or W1C) hit the same bit in the same cycle, the edge SHALL win and the bit stays 1.
REQ-026 PENDING write is W1C; ENABLE and MODE are RW.
REQ-027 STATUS = {11'b0, in_service_id[3:0], busy}.
REQ-028 reg_rdata SHALL be valid one cycle after reg_ren, and SHALL hold its value otherwise.

Reset
REQ-029 While rst_n=0: irq=0, vec_id=0, vec_addr=VEC_BASE, reg_rdata=0, PENDING=0, ENABLE=0, MODE=all 1s, in-service=0, synchronizers=0.
REQ-030 Reset asserted mid-service SHALL discard all pending and in-service state; there is no pulse on irq after release.

Configuration
REQ-031 With INTC_NEST_EN defined: in-service is an NUM_IRQ-bit vector; a winner is admitted only if its index is lower than the lowest set in-service bit (preemption).
REQ-032 Without INTC_NEST_EN: in-service is a single busy flag plus ID; irq=0 whenever busy=1, with no preemption.

Structure
REQ-033 Package intc_pkg SHALL hold the register-address constants, the STATUS field layout, and a priority-encoder function.
REQ-034 Sub-module intc_sync (per-channel 2-flop synchronizer and rising-edge detector) SHALL be instantiated NUM_IRQ times.

Verification
(Bench configuration for all scenarios: NUM_IRQ=8, VEC_BASE='h900, VEC_STRIDE='h10.)
REQ-035 Basic: ENABLE=0x08; pulse irq_src[3] -> irq=1 three edges later, vec_id=3, vec_addr='h930; irq_ack -> irq=0 and PENDING=0.
REQ-036 Priority: ENABLE=0xFF; raise src 5 and src 2 together -> vec_id=2; ack then iret -> vec_id=5, irq=1.
REQ-037 Nesting (INTC_NEST_EN): in service of id 4, raise src 1 -> irq=1, vec_addr='h910; raise src 6 -> irq stays 0 until the iret pairs complete. Without the macro, src 1 is held off until iret.
REQ-038 Level mode: MODE=0x00, hold src 0 high through ack and iret -> irq reasserts after iret; drop src 0 -> PENDING[0]=0 two edges later.
REQ-039 Races: W1C PENDING[3] in the same cycle as a new edge on src 3 -> PENDING[3]=1. Separately, iret with idle in-service -> STATUS=0x0000.
REQ-040 Reset: rst_n=0 mid-service with PENDING=0x21 -> all REQ-029 values immediately, and irq=0 after release.
